// File: rtl/remote_cmd_decoder.sv
// remote_cmd_decoder
// Parses framed command packets from the receive stack's 16-bit word stream.
// Each frame is one run of consecutive valid words:
//   {MAGIC,type}, seq, L, payload[0..L-1], checksum
// Payload words are written to an external RAM as they arrive, so RAM
// contents are only trustworthy after cmd_valid. Good frames raise
// cmd_valid. Bad, short, oversized or duplicate frames raise drop.
module remote_cmd_decoder #(
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter int         MAX_WORDS = 64,
    parameter int         AW        = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          axiiv,
    input  logic [15:0]   axiid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          cmd_valid,
    output logic [7:0]    cmd_type,
    output logic [15:0]   cmd_seq,
    output logic [AW:0]   cmd_len,
    output logic          drop,
    output logic [15:0]   drop_count
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
    localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEQ  = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_DROP = 3'd6
    } state_t;

    state_t        state_r, state_next_s;

    // Context of the frame currently being parsed
    logic [7:0]    type_r;
    logic [15:0]   seq_r;
    logic [AW:0]   len_r;
    logic [AW:0]   idx_r;
    logic [15:0]   sum_r;

    // Registered outputs
    logic          wr_en_r;
    logic [AW-1:0] wr_addr_r;
    logic [15:0]   wr_data_r;
    logic          cmd_valid_r;
    logic [7:0]    cmd_type_r;
    logic [15:0]   cmd_seq_r;
    logic [AW:0]   cmd_len_r;
    logic          drop_r;
    logic [15:0]   drop_count_r;
    logic          committed_r;

    // Control decoded from the current state and word
    logic          latch_type_s;
    logic          latch_seq_s;
    logic          latch_len_s;
    logic          accept_s;
    logic          frame_good_s;
    logic          frame_bad_s;
    logic          is_dup_s;
    logic          commit_s;
    logic          reject_s;

    // Next-state and per-cycle control decode
    always_comb begin
        state_next_s = state_r;
        latch_type_s = 1'b0;
        latch_seq_s  = 1'b0;
        latch_len_s  = 1'b0;
        accept_s     = 1'b0;
        frame_good_s = 1'b0;
        frame_bad_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (axiiv) begin
                    if (axiid[15:8] == MAGIC) begin
                        latch_type_s = 1'b1;
                        state_next_s = S_SEQ;
                    end else begin
                        state_next_s = S_DROP;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SEQ: begin
                if (axiiv) begin
                    latch_seq_s  = 1'b1;
                    state_next_s = S_LEN;
                end else begin
                    frame_bad_s  = 1'b1;
                    state_next_s = S_IDLE;
                end
            end
            S_LEN: begin
                if (axiiv) begin
                    if ((axiid == 16'h0000) || (axiid > MAX_LEN)) begin
                        state_next_s = S_DROP;
                    end else begin
                        latch_len_s  = 1'b1;
                        state_next_s = S_PAY;
                    end
                end else begin
                    frame_bad_s  = 1'b1;
                    state_next_s = S_IDLE;
                end
            end
            S_PAY: begin
                if (axiiv) begin
                    accept_s = 1'b1;
                    if ((idx_r + IDX_ONE) == len_r) begin
                        state_next_s = S_CSUM;
                    end else begin
                        state_next_s = S_PAY;
                    end
                end else begin
                    frame_bad_s  = 1'b1;
                    state_next_s = S_IDLE;
                end
            end
            S_CSUM: begin
                if (axiiv) begin
                    if (axiid == sum_r) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_DROP;
                    end
                end else begin
                    frame_bad_s  = 1'b1;
                    state_next_s = S_IDLE;
                end
            end
            S_DONE: begin
                if (axiiv) begin
                    state_next_s = S_DONE;
                end else begin
                    frame_good_s = 1'b1;
                    state_next_s = S_IDLE;
                end
            end
            S_DROP: begin
                if (axiiv) begin
                    state_next_s = S_DROP;
                end else begin
                    frame_bad_s  = 1'b1;
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // A passing frame repeating the last committed sequence number is
    // rejected. The first frame after reset is always eligible.
    assign is_dup_s = committed_r && (seq_r == cmd_seq_r);
    assign commit_s = frame_good_s && !is_dup_s;
    assign reject_s = frame_bad_s || (frame_good_s && is_dup_s);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Header capture, payload index and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            type_r <= 8'h00;
            seq_r  <= 16'h0000;
            len_r  <= '0;
            idx_r  <= '0;
            sum_r  <= 16'h0000;
        end else begin
            if (latch_type_s) begin
                type_r <= axiid[7:0];
            end
            if (latch_seq_s) begin
                seq_r <= axiid;
            end
            if (latch_len_s) begin
                len_r <= axiid[AW:0];
                idx_r <= '0;
                sum_r <= 16'h0000;
            end else if (accept_s) begin
                idx_r <= idx_r + IDX_ONE;
                sum_r <= sum_r + axiid;
            end
        end
    end

    // Payload RAM write port, one cycle behind the accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 16'h0000;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r <= idx_r[AW-1:0];
                wr_data_r <= axiid;
            end
        end
    end

    // Commit / drop strobes, committed command fields and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r  <= 1'b0;
            drop_r       <= 1'b0;
            cmd_type_r   <= 8'h00;
            cmd_seq_r    <= 16'h0000;
            cmd_len_r    <= '0;
            drop_count_r <= 16'h0000;
            committed_r  <= 1'b0;
        end else begin
            cmd_valid_r <= commit_s;
            drop_r      <= reject_s;
            if (commit_s) begin
                cmd_type_r  <= type_r;
                cmd_seq_r   <= seq_r;
                cmd_len_r   <= len_r;
                committed_r <= 1'b1;
            end
            if (reject_s) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign cmd_valid  = cmd_valid_r;
    assign cmd_type   = cmd_type_r;
    assign cmd_seq    = cmd_seq_r;
    assign cmd_len    = cmd_len_r;
    assign drop       = drop_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_remote_cmd_decoder.sv
// Testbench for remote_cmd_decoder: a cycle table of inputs with the
// outputs expected just after the clock edge that consumes them, followed
// by a hand-written latency check of the commit strobe.
module tb_remote_cmd_decoder;

    logic        clk;
    logic        rst;
    logic        axiiv;
    logic [15:0] axiid;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cmd_valid;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_seq;
    logic [6:0]  cmd_len;
    logic        drop;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    remote_cmd_decoder #(
        .MAGIC     (8'hA5),
        .MAX_WORDS (64),
        .AW        (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axiiv      (axiiv),
        .axiid      (axiid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_seq    (cmd_seq),
        .cmd_len    (cmd_len),
        .drop       (drop),
        .drop_count (drop_count)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [15:0] d;
        bit          we;
        logic [5:0]  wa;
        logic [15:0] wd;
        bit          cv;
        bit          dr;
        logic [7:0]  ty;
        logic [15:0] sq;
        logic [6:0]  ln;
        logic [15:0] dc;
    } vec_t;

    vec_t tbl[$];

    // Expected committed fields / drop counter while building the table
    logic [7:0]  st_ty = 8'h00;
    logic [15:0] st_sq = 16'h0000;
    logic [6:0]  st_ln = 7'd0;
    logic [15:0] st_dc = 16'h0000;

    task automatic put(input bit r, input bit v, input logic [15:0] d,
                       input bit we, input logic [5:0] wa, input logic [15:0] wd,
                       input bit cv, input bit dr);
        vec_t e;
        e.rst = r;  e.v = v;  e.d = d;
        e.we = we;  e.wa = wa; e.wd = wd;
        e.cv = cv;  e.dr = dr;
        e.ty = st_ty; e.sq = st_sq; e.ln = st_ln; e.dc = st_dc;
        tbl.push_back(e);
    endtask

    task automatic word(input logic [15:0] d);
        put(1'b0, 1'b1, d, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic pay(input logic [5:0] a, input logic [15:0] d);
        put(1'b0, 1'b1, d, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic end_commit(input logic [7:0] ty, input logic [15:0] sq, input logic [6:0] ln);
        st_ty = ty; st_sq = sq; st_ln = ln;
        put(1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic end_drop();
        st_dc = st_dc + 16'd1;
        put(1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic reset_cycle(input bit v, input logic [15:0] d);
        st_ty = 8'h00; st_sq = 16'h0000; st_ln = 7'd0; st_dc = 16'h0000;
        put(1'b1, v, d, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Standard frame: type 03, L=3, payload 1,2,3, checksum 6
    task automatic good3(input logic [15:0] sq);
        word(16'hA503); word(sq); word(16'h0003);
        pay(6'd0, 16'h0001); pay(6'd1, 16'h0002); pay(6'd2, 16'h0003);
        word(16'h0006);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input bit v, input logic [15:0] d);
        axiiv = v;
        axiid = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 16'h0000;

        // Reset state
        reset_cycle(1'b0, 16'h0000);
        reset_cycle(1'b0, 16'h0000);
        idle();

        // Good frame
        good3(16'h0007);
        end_commit(8'h03, 16'h0007, 7'd3);
        idle();

        // Bad checksum (fresh seq so only the trailer is wrong)
        word(16'hA503); word(16'h0009); word(16'h0003);
        pay(6'd0, 16'h0001); pay(6'd1, 16'h0002); pay(6'd2, 16'h0003);
        word(16'h0005);
        end_drop();
        idle();

        // Short frame cut after the second payload word
        word(16'hA503); word(16'h000A); word(16'h0003);
        pay(6'd0, 16'h0001); pay(6'd1, 16'h0002);
        end_drop();
        idle();

        // Oversized length 65: no writes for the following words
        word(16'hA503); word(16'h000B); word(16'h0041);
        word(16'h0001); word(16'h0002);
        end_drop();

        // Wrong magic
        word(16'hB503); word(16'h000D);
        end_drop();

        // Zero length
        word(16'hA503); word(16'h000D); word(16'h0000);
        end_drop();

        // Frame cut where the checksum should be
        word(16'hA503); word(16'h000E); word(16'h0001);
        pay(6'd0, 16'h0005);
        end_drop();
        idle();

        // Maximum length 64, payload 1..64, checksum 2080
        word(16'hA511); word(16'h000C); word(16'h0040);
        for (int i = 0; i < 64; i++) begin
            pay(6'(i), 16'(i + 1));
        end
        word(16'h0820);
        end_commit(8'h11, 16'h000C, 7'd64);
        idle();

        // Duplicate sequence: 7 commits, 7 again drops, 8 commits
        good3(16'h0007);
        end_commit(8'h03, 16'h0007, 7'd3);
        good3(16'h0007);
        end_drop();
        good3(16'h0008);
        end_commit(8'h03, 16'h0008, 7'd3);

        // Back-to-back, first frame with two extra trailing words
        word(16'hA505); word(16'h0030); word(16'h0002);
        pay(6'd0, 16'h1000); pay(6'd1, 16'h2000);
        word(16'h3000); word(16'hFFFF); word(16'hA5AA);
        end_commit(8'h05, 16'h0030, 7'd2);
        // Second frame: checksum wraps (FFFF + 0002 = 0001)
        word(16'hA506); word(16'h0031); word(16'h0002);
        pay(6'd0, 16'hFFFF); pay(6'd1, 16'h0002);
        word(16'h0001);
        end_commit(8'h06, 16'h0031, 7'd2);
        idle();

        // Reset mid-payload, then a good frame
        word(16'hA503); word(16'h0040); word(16'h0003);
        pay(6'd0, 16'h0001);
        reset_cycle(1'b1, 16'h0002);
        reset_cycle(1'b0, 16'h0000);
        idle();
        good3(16'h0007);
        end_commit(8'h03, 16'h0007, 7'd3);
        idle();
        idle();

        // Apply the table
        foreach (tbl[i]) begin
            rst   = tbl[i].rst;
            axiiv = tbl[i].v;
            axiid = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("strobes[%0d]", i),
                64'({wr_en, cmd_valid, drop,
                     (tbl[i].we ? wr_addr : 6'd0),
                     (tbl[i].we ? wr_data : 16'h0000)}),
                64'({tbl[i].we, tbl[i].cv, tbl[i].dr, tbl[i].wa, tbl[i].wd}));
            chk($sformatf("status[%0d]", i),
                64'({cmd_type, cmd_seq, cmd_len, drop_count}),
                64'({tbl[i].ty, tbl[i].sq, tbl[i].ln, tbl[i].dc}));
        end

        // Hand-written: commit latency is exactly one cycle after frame end
        begin
            int lat;
            lat = -1;
            send(1'b1, 16'hA57E); send(1'b1, 16'h0055); send(1'b1, 16'h0001);
            send(1'b1, 16'h1234); send(1'b1, 16'h1234);
            send(1'b0, 16'h0000);
            for (int k = 0; k < 8; k++) begin
                if (cmd_valid) begin
                    lat = k;
                    break;
                end
                send(1'b0, 16'h0000);
            end
            chk("commit_latency", 64'(lat), 64'(0));
            chk("commit_fields", 64'({cmd_type, cmd_seq, cmd_len, drop}),
                64'({8'h7E, 16'h0055, 7'd1, 1'b0}));
            send(1'b0, 16'h0000);
            chk("commit_one_cycle", 64'({cmd_valid, cmd_seq, drop_count}),
                64'({1'b0, 16'h0055, 16'h0000}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
